multicycle_ctrl_fsm: RTL and testbench
======================================

// Module: multicycle_ctrl_fsm
// PURPOSE
//  Main control FSM of the multicycle MIPS-subset datapath. Decodes opcode/funct and sequences
//  fetch, decode, execute, memory and writeback by driving every datapath mux/enable.
//  Memory latency is parametrised; supports R-type add/sub/and, addi, lw, sw, beq, bne and j.
//  Handles overflow and illegal-opcode exceptions through EPC and a fixed vector.
// PARAMETERS
//  MEM_WAIT  2  memory read latency in wait cycles after address issue; legal 0..15 (0 = no wait state)
//  STATE_W   7  width of state_out
// PORTS
//  clock          in   1  clock; all state changes on posedge clock
//  reset          in   1  asynchronous, active-high
//  opcode         in   6  IR[31:26]
//  funct          in   6  IR[5:0]
//  zero           in   1  ALU result == 0
//  overflow       in   1  ALU signed overflow (combinational, current cycle)
//  alu_src_a      out  2  0=PC, 2=A
//  alu_src_b      out  3  0=B, 1=const 4, 2=sext(imm), 3=sext(imm)<<2
//  alu_op         out  3  0=pass A, 1=add, 2=sub, 3=and
//  pc_source      out  3  0=ALU result, 1=ALUOut, 2=jump target, 3=exception vector
//  pc_write       out  1  PC load enable
//  mem_wr         out  1  memory write strobe
//  ir_write       out  1  IR load enable
//  iord           out  3  memory address select: 0=PC, 1=ALUOut
//  mem_to_reg     out  4  regfile data select: 0=ALUOut, 1=MDR, 5=stack-init constant
//  write_reg_a    out  1  A load enable
//  write_reg_b    out  1  B load enable
//  alu_out_write  out  1  ALUOut load enable
//  reg_dst        out  2  regfile destination: 0=rt, 1=$29, 3=rd
//  reg_write      out  1  regfile write enable
//  epc_write      out  1  EPC <- PC-4 enable
//  state_out      out  STATE_W  current state encoding (debug)
// BEHAVIOUR
//  - Moore outputs, combinational from state; any output not listed for a state is 0.
//    Registered: state and wait counter wcnt (width $clog2(MEM_WAIT+1)).
//  - RST(1): while reset is high and for 1 cycle after it falls.
//    Drives reg_write=1, reg_dst=1, mem_to_reg=5 (stack-pointer init); all else 0. Next: FETCH.
//  - FETCH(2): iord=0, alu_src_a=0, alu_src_b=1, alu_op=1, pc_source=0, pc_write=1; wcnt<=0.
//    Next: FWAIT if MEM_WAIT>0, else IRLD.
//  - FWAIT(3): wcnt increments; exits to IRLD in the cycle wcnt==MEM_WAIT-1 (exactly MEM_WAIT cycles).
//  - IRLD(4): ir_write=1. Next: DECODE.
//  - DECODE(5): write_reg_a=1, write_reg_b=1; alu_src_a=0, alu_src_b=3, alu_op=1, alu_out_write=1
//    (branch target). Dispatch:
//    - op 0x00 with funct 0x20/0x22/0x24 -> EXR
//    - 0x08 -> EXI
//    - 0x23/0x2B -> ADDR
//    - 0x04/0x05 -> BR
//    - 0x02 -> JMP
//    - anything else (incl. unknown funct) -> EXC
//  - EXR(6): alu_src_a=2, alu_src_b=0, alu_op=1/2/3 per funct, alu_out_write=1.
//    -> EXC if overflow && funct!=0x24, else WBR.
//  - EXI(7): alu_src_a=2, alu_src_b=2, alu_op=1, alu_out_write=1. -> EXC if overflow, else WBI.
//  - WBR(8): reg_write=1, reg_dst=3, mem_to_reg=0. WBI(9): same but reg_dst=0. Both -> FETCH.
//  - ADDR(10): alu_src_a=2, alu_src_b=2, alu_op=1, alu_out_write=1. -> MRD (lw) / STORE (sw).
//  - MRD(11): iord=1; wcnt counts MEM_WAIT cycles (min 1 cycle when MEM_WAIT=0), then LDWB.
//  - LDWB(12): reg_write=1, reg_dst=0, mem_to_reg=1. -> FETCH.
//  - STORE(13): iord=1, mem_wr=1 for exactly 1 cycle. -> FETCH.
//  - BR(14): alu_src_a=2, alu_src_b=0, alu_op=2, pc_source=1;
//    pc_write = zero (beq) or !zero (bne). -> FETCH.
//  - JMP(15): pc_source=2, pc_write=1. -> FETCH.
//  - EXC(16): epc_write=1, pc_source=3, pc_write=1; no regfile/memory write. -> FETCH.
//  - Latency (N=MEM_WAIT), in cycles from FETCH entry to next FETCH:
//    - R/addi: N+5
//    - beq/bne/j/exception: N+4 (from DECODE)
//    - sw: N+5
//    - lw: 2N+5 (N=0: 6)
//  - Reset mid-instruction: state->RST immediately (async); wcnt->0;
//    no mem_wr/reg_write other than RST's sp init.
//  - Unused state encodings go to RST on the next clock.
//  - overflow/zero are ignored in every state except EXR/EXI/BR.
// TESTING
//  - MEM_WAIT=2, reset pulse -> in RST: reg_write=1, reg_dst=1, mem_to_reg=5;
//    1 cycle after release: state_out=2, pc_write=1.
//  - add (op 0, funct 0x20), overflow=0 -> states 2,3,3,4,5,6,8,2;
//    reg_write=1 with reg_dst=3 only in the WBR cycle; 7 cycles total.
//  - lw (0x23), MEM_WAIT=2 -> 2,3,3,4,5,10,11,11,12,2; mem_to_reg=1 in LDWB.
//    Same test with MEM_WAIT=0 -> 2,4,5,10,11,12.
//  - beq with zero=1 -> pc_write=1, pc_source=1 in BR. With zero=0 -> pc_write=0.
//    bne inverts both results.
//  - addi with overflow=1 in EXI -> EXC: epc_write=1, pc_source=3; reg_write never asserted.
//    Opcode 0x3F -> EXC straight from DECODE.
//  - sw, reset asserted during STORE -> mem_wr drops same cycle, state_out=1, wcnt=0,
//    next fetch proceeds normally.

Source files
------------

// File: rtl/multicycle_ctrl_fsm.sv
// Main control FSM of the multicycle MIPS-subset datapath: sequences fetch/decode/execute/
// memory/writeback, drives every datapath mux/enable, and traps overflow or illegal opcodes.
module multicycle_ctrl_fsm #(
    parameter int MEM_WAIT = 2,
    parameter int STATE_W  = 7
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [5:0]         opcode,
    input  logic [5:0]         funct,
    input  logic               zero,
    input  logic               overflow,
    output logic [1:0]         alu_src_a,
    output logic [2:0]         alu_src_b,
    output logic [2:0]         alu_op,
    output logic [2:0]         pc_source,
    output logic               pc_write,
    output logic               mem_wr,
    output logic               ir_write,
    output logic [2:0]         iord,
    output logic [3:0]         mem_to_reg,
    output logic               write_reg_a,
    output logic               write_reg_b,
    output logic               alu_out_write,
    output logic [1:0]         reg_dst,
    output logic               reg_write,
    output logic               epc_write,
    output logic [STATE_W-1:0] state_out
);

    localparam int WCNT_W = (MEM_WAIT > 0) ? $clog2(MEM_WAIT + 1) : 1;
    // Last count value of a wait phase; with no wait states MRD still lasts one cycle.
    localparam logic [WCNT_W-1:0] WLAST = (MEM_WAIT > 0) ? WCNT_W'(MEM_WAIT - 1) : '0;
    localparam bit HAS_WAIT = (MEM_WAIT > 0);

    localparam logic [STATE_W-1:0] S_RST    = STATE_W'(1);
    localparam logic [STATE_W-1:0] S_FETCH  = STATE_W'(2);
    localparam logic [STATE_W-1:0] S_FWAIT  = STATE_W'(3);
    localparam logic [STATE_W-1:0] S_IRLD   = STATE_W'(4);
    localparam logic [STATE_W-1:0] S_DECODE = STATE_W'(5);
    localparam logic [STATE_W-1:0] S_EXR    = STATE_W'(6);
    localparam logic [STATE_W-1:0] S_EXI    = STATE_W'(7);
    localparam logic [STATE_W-1:0] S_WBR    = STATE_W'(8);
    localparam logic [STATE_W-1:0] S_WBI    = STATE_W'(9);
    localparam logic [STATE_W-1:0] S_ADDR   = STATE_W'(10);
    localparam logic [STATE_W-1:0] S_MRD    = STATE_W'(11);
    localparam logic [STATE_W-1:0] S_LDWB   = STATE_W'(12);
    localparam logic [STATE_W-1:0] S_STORE  = STATE_W'(13);
    localparam logic [STATE_W-1:0] S_BR     = STATE_W'(14);
    localparam logic [STATE_W-1:0] S_JMP    = STATE_W'(15);
    localparam logic [STATE_W-1:0] S_EXC    = STATE_W'(16);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_AND   = 6'h24;

    logic [STATE_W-1:0] state, next_state;
    logic [WCNT_W-1:0]  wcnt;
    logic               wcnt_last;
    logic               is_rtype;

    assign wcnt_last = (wcnt == WLAST);
    assign is_rtype  = (opcode == OP_RTYPE) &&
                       (funct == FN_ADD || funct == FN_SUB || funct == FN_AND);
    assign state_out = state;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= S_RST;
            wcnt  <= '0;
        end else begin
            state <= next_state;
            if ((state == S_FWAIT || state == S_MRD) && !wcnt_last)
                wcnt <= wcnt + 1'b1;
            else
                wcnt <= '0;
        end
    end

    always_comb begin
        next_state = S_RST;
        case (state)
            S_RST:    next_state = S_FETCH;
            S_FETCH:  next_state = HAS_WAIT ? S_FWAIT : S_IRLD;
            S_FWAIT:  next_state = wcnt_last ? S_IRLD : S_FWAIT;
            S_IRLD:   next_state = S_DECODE;
            S_DECODE: begin
                if (is_rtype)                              next_state = S_EXR;
                else if (opcode == OP_ADDI)                next_state = S_EXI;
                else if (opcode == OP_LW || opcode == OP_SW) next_state = S_ADDR;
                else if (opcode == OP_BEQ || opcode == OP_BNE) next_state = S_BR;
                else if (opcode == OP_J)                   next_state = S_JMP;
                else                                       next_state = S_EXC;
            end
            // AND cannot overflow, so its overflow flag is not a trap source.
            S_EXR:    next_state = (overflow && funct != FN_AND) ? S_EXC : S_WBR;
            S_EXI:    next_state = overflow ? S_EXC : S_WBI;
            S_ADDR:   next_state = (opcode == OP_LW) ? S_MRD : S_STORE;
            S_MRD:    next_state = wcnt_last ? S_LDWB : S_MRD;
            S_WBR, S_WBI, S_LDWB, S_STORE, S_BR, S_JMP, S_EXC:
                      next_state = S_FETCH;
            default:  next_state = S_RST;
        endcase
    end

    always_comb begin
        alu_src_a     = 2'd0;
        alu_src_b     = 3'd0;
        alu_op        = 3'd0;
        pc_source     = 3'd0;
        pc_write      = 1'b0;
        mem_wr        = 1'b0;
        ir_write      = 1'b0;
        iord          = 3'd0;
        mem_to_reg    = 4'd0;
        write_reg_a   = 1'b0;
        write_reg_b   = 1'b0;
        alu_out_write = 1'b0;
        reg_dst       = 2'd0;
        reg_write     = 1'b0;
        epc_write     = 1'b0;
        case (state)
            S_RST: begin
                reg_write  = 1'b1;
                reg_dst    = 2'd1;
                mem_to_reg = 4'd5;
            end
            S_FETCH: begin
                alu_src_b = 3'd1;
                alu_op    = 3'd1;
                pc_write  = 1'b1;
            end
            S_IRLD: ir_write = 1'b1;
            S_DECODE: begin
                write_reg_a   = 1'b1;
                write_reg_b   = 1'b1;
                alu_src_b     = 3'd3;
                alu_op        = 3'd1;
                alu_out_write = 1'b1;
            end
            S_EXR: begin
                alu_src_a     = 2'd2;
                alu_out_write = 1'b1;
                case (funct)
                    FN_SUB:  alu_op = 3'd2;
                    FN_AND:  alu_op = 3'd3;
                    default: alu_op = 3'd1;
                endcase
            end
            S_EXI, S_ADDR: begin
                alu_src_a     = 2'd2;
                alu_src_b     = 3'd2;
                alu_op        = 3'd1;
                alu_out_write = 1'b1;
            end
            S_WBR: begin
                reg_write = 1'b1;
                reg_dst   = 2'd3;
            end
            S_WBI: reg_write = 1'b1;
            S_MRD: iord = 3'd1;
            S_LDWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 4'd1;
            end
            S_STORE: begin
                iord   = 3'd1;
                mem_wr = 1'b1;
            end
            S_BR: begin
                alu_src_a = 2'd2;
                alu_op    = 3'd2;
                pc_source = 3'd1;
                pc_write  = (opcode == OP_BNE) ? !zero : zero;
            end
            S_JMP: begin
                pc_source = 3'd2;
                pc_write  = 1'b1;
            end
            S_EXC: begin
                epc_write = 1'b1;
                pc_source = 3'd3;
                pc_write  = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Bench for multicycle_ctrl_fsm: two instances (MEM_WAIT=2 and 0) run directed and random
// instruction streams; a per-cycle expected trace is queued and compared at negedge.
module tb_multicycle_ctrl_fsm;

    logic       clock = 1'b0;
    logic [1:0] rst = 2'b11;
    logic [5:0] op_s [2];
    logic [5:0] fn_s [2];
    logic [1:0] zr = 2'b00;
    logic [1:0] ov = 2'b00;
    logic [34:0] act [2];

    logic [34:0] exp_q[$];
    logic [34:0] exp0_q[$];
    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        logic [1:0] asa;
        logic [2:0] asb, aop, pcs, iord;
        logic       pcw, mwr, irw, wa, wb, aow, rw, ew;
        logic [3:0] m2r;
        logic [1:0] rd;
        logic [6:0] so;
        multicycle_ctrl_fsm #(.MEM_WAIT(g == 0 ? 2 : 0), .STATE_W(7)) dut (
            .clock(clock), .reset(rst[g]), .opcode(op_s[g]), .funct(fn_s[g]),
            .zero(zr[g]), .overflow(ov[g]),
            .alu_src_a(asa), .alu_src_b(asb), .alu_op(aop), .pc_source(pcs),
            .pc_write(pcw), .mem_wr(mwr), .ir_write(irw), .iord(iord),
            .mem_to_reg(m2r), .write_reg_a(wa), .write_reg_b(wb),
            .alu_out_write(aow), .reg_dst(rd), .reg_write(rw), .epc_write(ew),
            .state_out(so)
        );
        assign act[g] = {so, asa, asb, aop, pcs, pcw, mwr, irw, iord, m2r, wa, wb, aow, rd, rw, ew};
    end

    // Expected outputs for one cycle spent in phase s of the instruction (op, fn, zero).
    function automatic logic [34:0] exp_vec(int s, logic [5:0] op, logic [5:0] fn, logic z);
        logic [1:0] asa = 0; logic [2:0] asb = 0, aop = 0, pcs = 0, iord = 0;
        logic pcw = 0, mwr = 0, irw = 0, wa = 0, wb = 0, aow = 0, rw = 0, ew = 0;
        logic [3:0] m2r = 0; logic [1:0] rd = 0;
        case (s)
            1:  begin rw = 1; rd = 1; m2r = 5; end
            2:  begin pcw = 1; asb = 1; aop = 1; end
            4:  irw = 1;
            5:  begin wa = 1; wb = 1; asb = 3; aop = 1; aow = 1; end
            6:  begin asa = 2; aow = 1; aop = (fn == 6'h22) ? 3'd2 : (fn == 6'h24) ? 3'd3 : 3'd1; end
            7, 10: begin asa = 2; asb = 2; aop = 1; aow = 1; end
            8:  begin rw = 1; rd = 3; end
            9:  rw = 1;
            11: iord = 1;
            12: begin rw = 1; m2r = 1; end
            13: begin iord = 1; mwr = 1; end
            14: begin asa = 2; aop = 2; pcs = 1; pcw = (op == 6'h05) ? !z : z; end
            15: begin pcs = 2; pcw = 1; end
            16: begin ew = 1; pcs = 3; pcw = 1; end
            default: ;
        endcase
        return {7'(s), asa, asb, aop, pcs, pcw, mwr, irw, iord, m2r, wa, wb, aow, rd, rw, ew};
    endfunction

    // Phase sequence of one instruction, from the instruction-class rules.
    task automatic build(input int mw, input logic [5:0] op, input logic [5:0] fn,
                         input logic ovf, output int st[16], output int len);
        int q[$];
        q.push_back(2);
        repeat (mw) q.push_back(3);
        q.push_back(4);
        q.push_back(5);
        if (op == 6'h00 && (fn == 6'h20 || fn == 6'h22 || fn == 6'h24)) begin
            q.push_back(6);
            q.push_back((ovf && fn != 6'h24) ? 16 : 8);
        end else if (op == 6'h08) begin
            q.push_back(7);
            q.push_back(ovf ? 16 : 9);
        end else if (op == 6'h23) begin
            q.push_back(10);
            repeat ((mw > 0) ? mw : 1) q.push_back(11);
            q.push_back(12);
        end else if (op == 6'h2B) begin
            q.push_back(10);
            q.push_back(13);
        end else if (op == 6'h04 || op == 6'h05) q.push_back(14);
        else if (op == 6'h02) q.push_back(15);
        else q.push_back(16);
        st = '{default: 0};
        len = q.size();
        for (int k = 0; k < len; k++) st[k] = q[k];
    endtask

    task automatic push(input int i, input logic [34:0] v);
        if (i == 0) exp_q.push_back(v);
        else exp0_q.push_back(v);
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Caller has just stepped; reset is held two cycles, then one more RST cycle follows release.
    task automatic reset_rest(input int i);
        rst[i] = 1'b1;
        push(i, exp_vec(1, 6'h00, 6'h00, 1'b0));
        step();
        push(i, exp_vec(1, 6'h00, 6'h00, 1'b0));
        step();
        rst[i] = 1'b0;
        push(i, exp_vec(1, 6'h00, 6'h00, 1'b0));
    endtask

    task automatic do_reset(input int i);
        step();
        reset_rest(i);
    endtask

    task automatic run_instr(input int i, input logic [5:0] op, input logic [5:0] fn,
                             input logic ovf, input logic z, input int abort_st);
        int st[16];
        int len;
        build((i == 0) ? 2 : 0, op, fn, ovf, st, len);
        for (int c = 0; c < len; c++) begin
            step();
            if (st[c] == abort_st) begin
                reset_rest(i);
                return;
            end
            op_s[i] = op;
            fn_s[i] = fn;
            zr[i] = (st[c] == 14) ? z : 1'($urandom_range(0, 1));
            ov[i] = (st[c] == 6 || st[c] == 7) ? ovf : 1'($urandom_range(0, 1));
            push(i, exp_vec(st[c], op, fn, z));
        end
    endtask

    task automatic run_stream(input int i);
        logic [5:0] op, fn;
        int k, ab;
        do_reset(i);
        run_instr(i, 6'h00, 6'h20, 1'b0, 1'b0, 0);  // add
        run_instr(i, 6'h23, 6'h00, 1'b0, 1'b0, 0);  // lw
        run_instr(i, 6'h04, 6'h00, 1'b0, 1'b1, 0);  // beq taken
        run_instr(i, 6'h04, 6'h00, 1'b1, 1'b0, 0);  // beq not taken
        run_instr(i, 6'h05, 6'h00, 1'b0, 1'b1, 0);  // bne not taken
        run_instr(i, 6'h05, 6'h00, 1'b0, 1'b0, 0);  // bne taken
        run_instr(i, 6'h08, 6'h00, 1'b1, 1'b0, 0);  // addi overflow trap
        run_instr(i, 6'h08, 6'h11, 1'b0, 1'b0, 0);
        run_instr(i, 6'h00, 6'h22, 1'b1, 1'b0, 0);  // sub overflow trap
        run_instr(i, 6'h00, 6'h24, 1'b1, 1'b0, 0);  // and ignores overflow
        run_instr(i, 6'h00, 6'h25, 1'b0, 1'b0, 0);  // unknown funct
        run_instr(i, 6'h3F, 6'h00, 1'b0, 1'b0, 0);  // illegal opcode
        run_instr(i, 6'h02, 6'h00, 1'b0, 1'b0, 0);  // j
        run_instr(i, 6'h2B, 6'h00, 1'b0, 1'b0, 13); // sw, reset during STORE
        run_instr(i, 6'h2B, 6'h00, 1'b0, 1'b0, 0);
        run_instr(i, 6'h00, 6'h20, 1'b0, 1'b0, 0);
        for (int n = 0; n < 80; n++) begin
            k  = $urandom_range(0, 9);
            fn = 6'($urandom);
            case (k)
                0, 1: begin op = 6'h00; fn = 6'h20 + 6'(2 * $urandom_range(0, 2)); end
                2: op = 6'h08;
                3: op = 6'h23;
                4: op = 6'h2B;
                5: op = 6'h04;
                6: op = 6'h05;
                7: op = 6'h02;
                8: op = 6'($urandom);
                default: op = 6'h00;
            endcase
            ab = ($urandom_range(0, 9) == 0) ? $urandom_range(2, 16) : 0;
            run_instr(i, op, fn, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ab);
        end
    endtask

    task automatic check(input int i, input logic [34:0] a, input logic [34:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL dut%0d cycle: got state=%0d outs=%h, expected state=%0d outs=%h",
                     i, a[34:28], a[27:0], e[34:28], e[27:0]);
        end
    endtask

    always @(negedge clock) begin
        if (exp_q.size() > 0) check(0, act[0], exp_q.pop_front());
        if (exp0_q.size() > 0) check(1, act[1], exp0_q.pop_front());
    end

    initial begin
        op_s[0] = 6'h00; op_s[1] = 6'h00;
        fn_s[0] = 6'h00; fn_s[1] = 6'h00;
        fork
            run_stream(0);
            run_stream(1);
        join
        repeat (3) @(posedge clock);
        checks++;
        if (exp_q.size() + exp0_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d unchecked entries, expected 0", exp_q.size() + exp0_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
